// File: rtl/pdec_list_crc_chk.sv
// Polar-decoder list CRC checker: reads back the decoded bits of 8 list paths
// from the list RAM, runs 8 parallel CRC dividers at 4 bits per path per cycle,
// and reports the pass mask and the lowest-numbered passing path.
module pdec_list_crc_chk #(
  parameter int                WID_K    = 8,
  parameter int                CRC_W    = 6,
  parameter logic [CRC_W-1:0]  CRC_POLY = 6'h21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ck_start,
  input  logic [WID_K:0]     ck_word_num,
  output logic [7:0]         ck2sram_list_ren,
  output logic [WID_K-1:0]   ck2sram_list_raddr,
  input  logic [31:0]        sram2ck_list_rdata,
  output logic               ck_busy,
  output logic               ck_done,
  output logic [7:0]         ck_crc_pass,
  output logic [2:0]         ck_sel_path,
  output logic               ck_sel_valid
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [WID_K-1:0]       addr_q;
  logic [WID_K-1:0]       last_q;
  logic                   ren_q;
  logic [1:0]             vld_sr_q;
  logic                   busy_q;
  logic                   done_q;
  logic [7:0]             pass_q;
  logic [2:0]             sel_q;
  logic                   sel_vld_q;

  logic [7:0][CRC_W-1:0]  crc_q;
  logic [7:0][CRC_W-1:0]  crc_d;
  logic [7:0]             pass_d;
  logic [2:0]             sel_d;
  logic                   sel_vld_d;

  logic                   start_acc;
  logic [WID_K:0]         word_m1;
  logic                   last_absorb;

  // Four serial CRC steps, MSB of the nibble first.
  function automatic logic [CRC_W-1:0] crc_step4(input logic [CRC_W-1:0] c,
                                                 input logic [3:0]       d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 3; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  // A start is only honoured while idle; busy covers all other states.
  assign start_acc   = ck_start && (state_q == IDLE);
  // Word count of 0 behaves like 1, so the last address is never negative.
  assign word_m1     = (ck_word_num == '0) ? '0 : ck_word_num - (WID_K+1)'(1);
  // Last returned word is on the bus and nothing is still in flight behind it.
  assign last_absorb = vld_sr_q[1] && !vld_sr_q[0];

  // Per-lane next CRC: advance only when a valid return word is on the bus.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign crc_d[gi]  = vld_sr_q[1] ? crc_step4(crc_q[gi], sram2ck_list_rdata[4*gi +: 4])
                                    : crc_q[gi];
    assign pass_d[gi] = (crc_d[gi] == '0);
  end

  // Priority encode with lane 0 winning; scanning downward lets the lowest hit overwrite.
  always_comb begin
    sel_d     = '0;
    sel_vld_d = |pass_d;
    for (int i = 7; i >= 0; i--) begin
      if (pass_d[i]) sel_d = 3'(i);
    end
  end

  // CRC registers: cleared by an accepted start, otherwise follow the lane update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (start_acc) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  // Control FSM with registered read port, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      ren_q     <= 1'b0;
      vld_sr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      vld_sr_q <= {vld_sr_q[0], ren_q};
      case (state_q)
        IDLE: begin
          if (ck_start) begin
            last_q  <= word_m1[WID_K-1:0];
            addr_q  <= '0;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          // Address may wrap after the final read; no read is issued then.
          addr_q <= addr_q + 1'b1;
          if (addr_q == last_q) begin
            ren_q   <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_absorb) begin
            pass_q    <= pass_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ck2sram_list_ren   = {8{ren_q}};
  assign ck2sram_list_raddr = addr_q;
  assign ck_busy            = busy_q;
  assign ck_done            = done_q;
  assign ck_crc_pass        = pass_q;
  assign ck_sel_path        = sel_q;
  assign ck_sel_valid       = sel_vld_q;

endmodule

// File: doc/pdec_list_crc_chk.md
# pdec_list_crc_chk

Polar-decoder list CRC checker. After the path-update stage has written the decoded information bits of the 8 list paths into the list RAM, this block reads them back over the list RAM read port. It runs 8 parallel CRC dividers at 4 bits per path per cycle, then reports a pass/fail mask and the index of the lowest-numbered passing path. It is the consumer on the `ck2sram_list_*` / `sram2ck_list_rdata` port of the SRAM top, and is the reader counterpart of the path-update writer.

## Interface
- `WID_K`, default 8: list RAM address width; max words per path = 2^WID_K.
- `CRC_W`, default 6: CRC width (2..24).
- `CRC_POLY`, default 6'h21: generator polynomial without the x^CRC_W term; the default is x^6+x^5+1.
- `clk` input, 1: clock.
- `rst_n` input, 1: reset; asynchronous assertion, active-low.
- `ck_start` input, 1: one-cycle start pulse. Ignored while `ck_busy`=1.
- `ck_word_num` input, WID_K+1: number of 4-bit words per path to read, 1..2^WID_K. Sampled on an accepted `ck_start`. The value 0 is treated as 1.
- `ck2sram_list_ren` output, 8: per-lane read enables; all 8 bits are driven identically.
- `ck2sram_list_raddr` output, WID_K: list RAM read address.
- `sram2ck_list_rdata` input, 32: lane p data on bits [4p+3:4p].
- `ck_busy` output, 1: high from the cycle after an accepted start until the cycle `ck_done` is asserted, inclusive.
- `ck_done` output, 1: one-cycle pulse when the results are valid.
- `ck_crc_pass` output, 8: bit p = 1 if path p has remainder 0. Held until the next `ck_done`.
- `ck_sel_path` output, 3: lowest p with `ck_crc_pass`[p]=1, or 0 if none pass. Held.
- `ck_sel_valid` output, 1: 1 if any path passed. Held.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - An accepted `ck_start` latches `ck_word_num`, clears the address counter and clears all 8 CRC registers to 0.
  - Next state is READ.
- READ:
  - `ren`=8'hFF and `raddr`=counter; the counter increments every cycle.
  - After the word at address `ck_word_num`-1 is issued, next state is DRAIN.
  - Reads are back-to-back, with no gaps.
- DRAIN: wait until the last returned word is absorbed, then go to DONE.
- DONE:
  - Register the results and pulse `ck_done` for one cycle.
  - Next state is IDLE.
- Return data tracking: a 2-stage valid shift register tracks read returns. `vld_sr`[0] is set from the `ren` issue, and `vld_sr`[1] marks data valid on `sram2ck_list_rdata`. Each valid word updates all 8 CRC registers.
- CRC update per lane:
  - The 4 bits are processed serially in one cycle, bit [4p+3] first and bit [4p] last.
  - For each bit b: fb = crc[CRC_W-1] ^ b; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - The initial value is 0. There is no final XOR and no reflection.
- Pass: `ck_crc_pass`[p] = (crc_p == 0) after the last word. The selection is a priority encode on lane 0 first.
- The block never writes the list RAM. The upstream writer must have completed all writes before `ck_start`. Concurrent writes are not supported; correct results are not guaranteed.
- Outputs are registered. They change only at DONE, and on reset.

## Timing
- Reset values:
  - `ren`=0, `raddr`=0, `ck_busy`=0, `ck_done`=0.
  - `ck_crc_pass`=8'h00, `ck_sel_path`=0, `ck_sel_valid`=0.
  - FSM = IDLE and `vld_sr`=0.
- Read latency: `ren` asserted in cycle t gives data valid on `sram2ck_list_rdata` in cycle t+2 (SRAM address stage plus the registered-output stage in the SRAM top).
- Start-to-done latency: `ck_start` in cycle 0 → first `ren` in cycle 1 → last `ren` in cycle N → last data in cycle N+2, absorbed at the end of N+2 → `ck_done` in cycle N+3. Total = `ck_word_num`+3 cycles.
- `ck_busy` is high in cycles 1..N+3. A `ck_start` in cycle N+3 is ignored. The earliest accepted restart is cycle N+4.
- Address wrap: with `ck_word_num`=2^WID_K, the last address is 2^WID_K-1. The counter may wrap to 0 afterwards but issues no further read.
- Reset mid-operation: everything returns to reset values at once, `ren` drops asynchronously, and in-flight returns are discarded because `vld_sr` is cleared.

## Test plan
- Reset: hold `rst_n`=0 with random RAM data → all outputs at reset values, `ren`=0. Then release and send no start → `ck_done` never pulses.
- All-zero data, `ck_word_num`=4 → `ren` in cycles 1..4 at `raddr` 0..3; `ck_done` in cycle 7; `ck_crc_pass`=8'hFF, `ck_sel_path`=0, `ck_sel_valid`=1.
- `ck_word_num`=2, every lane reads word0=4'b0110, word1=4'b0001 (codeword = g) except lane 3 word1=4'b0000 → `ck_crc_pass`=8'hF7, `ck_sel_path`=0.
- Lanes 0..4 hold 4'b0001 in the last word and lanes 5..7 are zero; `ck_word_num`=3 → `ck_crc_pass`=8'hE0, `ck_sel_path`=5, `ck_sel_valid`=1. With every lane failing → 8'h00, sel=0, `ck_sel_valid`=0.
- `ck_word_num`=256 (WID_K=8) → 256 consecutive reads at addresses 0..255, `ck_done` at cycle 259. A `ck_start` pulsed mid-run is ignored, and a `ck_start` in cycle 260 is accepted.
- Assert `rst_n`=0 during READ (cycle 3 of a 10-word run) → `ren` drops immediately. After release, a new start with zero data gives 8'hFF with no corruption from the aborted run.
